// File: rtl/alu_1_if.sv
// alu_1_if -- operand/command bus and registered result bus of the alu_1 ALU.
//   Parameter INPUT : operand width in bits; res is 2*INPUT bits wide.
//   Request side (driven by master): ce, mode, cmd[3:0], valid[1:0],
//     opa/opb[INPUT-1:0], cin.
//   Result side (driven by slave): res[2*INPUT-1:0], cout, oflow, err, g, l, e.
interface alu_1_if #(
  parameter int INPUT = 8
);
  logic                 ce;
  logic                 mode;
  logic [3:0]           cmd;
  logic [1:0]           valid;
  logic [INPUT-1:0]     opa;
  logic [INPUT-1:0]     opb;
  logic                 cin;
  logic [2*INPUT-1:0]   res;
  logic                 cout;
  logic                 oflow;
  logic                 err;
  logic                 g;
  logic                 l;
  logic                 e;

  modport master (
    output ce, mode, cmd, valid, opa, opb, cin,
    input  res, cout, oflow, err, g, l, e
  );

  modport slave (
    input  ce, mode, cmd, valid, opa, opb, cin,
    output res, cout, oflow, err, g, l, e
  );
endinterface

// File: rtl/alu_1.sv
// alu_1 -- single-cycle registered ALU with arithmetic and logical command sets.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; clears every output
//   bus : alu_1_if.slave; ce=1 registers a new result, ce=0 holds outputs.
//         mode=1 selects arithmetic commands, mode=0 logical commands.
//         valid[0]/valid[1] qualify opa/opb; a missing operand or an undefined
//         command yields res=0, err=1 and all other flags 0.
module alu_1 #(
  parameter int INPUT = 8
) (
  input  logic   clk,
  input  logic   rst,
  alu_1_if.slave bus
);
  localparam int W   = INPUT;
  localparam int RW  = 2 * INPUT;
  localparam int SHW = $clog2(INPUT);

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A, A_INC_B, A_DEC_B,
    A_CMP, A_MUL_INC, A_MUL_SHL, A_SADD, A_SSUB
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_A, L_NOT_B,
    L_SHR_A, L_SHL_A, L_SHR_B, L_SHL_B, L_ROL, L_ROR
  } logic_cmd_e;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          cout;
    logic          oflow;
    logic          err;
    logic          g;
    logic          l;
    logic          e;
  } result_t;

  result_t         nxt, cur;
  logic [W-1:0]    a, b, lres;
  logic [W+1:0]    za, zb, zc, zone;   // one spare bit so bit W+1 is the borrow
  logic [RW-1:0]   ra, rb, rone;
  logic [W+1:0]    sum;
  logic signed [W:0] ssum;
  logic [RW-1:0]   dbl;
  logic [SHW-1:0]  amt;
  logic [1:0]      need;
  logic            undef_cmd;

  assign a    = bus.opa;
  assign b    = bus.opb;
  assign za   = {2'b00, a};
  assign zb   = {2'b00, b};
  assign zc   = {{(W+1){1'b0}}, bus.cin};
  assign zone = {{(W+1){1'b0}}, 1'b1};
  assign ra   = {{W{1'b0}}, a};
  assign rb   = {{W{1'b0}}, b};
  assign rone = {{(RW-1){1'b0}}, 1'b1};
  assign amt  = b[SHW-1:0];

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    nxt       = '0;
    lres      = '0;
    sum       = '0;
    ssum      = '0;
    dbl       = '0;
    need      = 2'b11;
    undef_cmd = 1'b0;

    if (bus.mode) begin
      case (bus.cmd)
        A_ADD:     begin sum = za + zb;       nxt.res = RW'(sum[W:0]); nxt.cout  = sum[W];   end
        A_SUB:     begin sum = za - zb;       nxt.res = RW'(sum[W:0]); nxt.oflow = sum[W+1]; end
        A_ADD_CIN: begin sum = za + zb + zc;  nxt.res = RW'(sum[W:0]); nxt.cout  = sum[W];   end
        A_SUB_CIN: begin sum = za - zb - zc;  nxt.res = RW'(sum[W:0]); nxt.oflow = sum[W+1]; end
        A_INC_A: begin
          need = 2'b01; sum = za + zone; nxt.res = RW'(sum[W:0]); nxt.cout = sum[W];
        end
        A_DEC_A: begin
          need = 2'b01; sum = za - zone; nxt.res = RW'(sum[W:0]); nxt.oflow = sum[W+1];
        end
        A_INC_B: begin
          need = 2'b10; sum = zb + zone; nxt.res = RW'(sum[W:0]); nxt.cout = sum[W];
        end
        A_DEC_B: begin
          need = 2'b10; sum = zb - zone; nxt.res = RW'(sum[W:0]); nxt.oflow = sum[W+1];
        end
        A_CMP: begin
          nxt.g = (a > b);
          nxt.l = (a < b);
          nxt.e = (a == b);
        end
        A_MUL_INC: nxt.res = (ra + rone) * (rb + rone);
        // A<<1 keeps its carried-out bit; the product is then truncated to RW bits.
        A_MUL_SHL: nxt.res = {{(W-1){1'b0}}, a, 1'b0} * rb;
        A_SADD, A_SSUB: begin
          if (bus.cmd == A_SADD) ssum = $signed({a[W-1], a}) + $signed({b[W-1], b});
          else                   ssum = $signed({a[W-1], a}) - $signed({b[W-1], b});
          nxt.res   = {{(RW-W-1){ssum[W]}}, ssum};
          // W-bit overflow: the W+1-bit result does not fit back into W bits.
          nxt.oflow = ssum[W] ^ ssum[W-1];
          nxt.g     = ($signed(a) >  $signed(b));
          nxt.l     = ($signed(a) <  $signed(b));
          nxt.e     = (a == b);
        end
        default: undef_cmd = 1'b1;
      endcase
    end else begin
      case (bus.cmd)
        L_AND:   lres = a & b;
        L_NAND:  lres = ~(a & b);
        L_OR:    lres = a | b;
        L_NOR:   lres = ~(a | b);
        L_XOR:   lres = a ^ b;
        L_XNOR:  lres = ~(a ^ b);
        L_NOT_A: begin need = 2'b01; lres = ~a;      end
        L_NOT_B: begin need = 2'b10; lres = ~b;      end
        L_SHR_A: begin need = 2'b01; lres = a >> 1;  end
        L_SHL_A: begin need = 2'b01; lres = a << 1;  end
        L_SHR_B: begin need = 2'b10; lres = b >> 1;  end
        L_SHL_B: begin need = 2'b10; lres = b << 1;  end
        // Rotates shift a doubled copy of A and keep the window that wraps around.
        L_ROL: begin
          dbl = {a, a} << amt; lres = dbl[RW-1:W]; nxt.err = |(b >> SHW);
        end
        L_ROR: begin
          dbl = {a, a} >> amt; lres = dbl[W-1:0];  nxt.err = |(b >> SHW);
        end
        default: undef_cmd = 1'b1;
      endcase
      nxt.res = {{W{1'b0}}, lres};
    end

    if (undef_cmd || ((bus.valid & need) != need)) begin
      nxt     = '0;
      nxt.err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst)         cur <= '0;
    else if (bus.ce) cur <= nxt;
  end

  assign bus.res   = cur.res;
  assign bus.cout  = cur.cout;
  assign bus.oflow = cur.oflow;
  assign bus.err   = cur.err;
  assign bus.g     = cur.g;
  assign bus.l     = cur.l;
  assign bus.e     = cur.e;
endmodule

// File: tb/tb_alu_1.sv
// tb_alu_1 -- self-checking bench for alu_1 (INPUT=8): directed boundary steps,
// reset/hold behaviour, then randomized commands against an integer model.
module tb_alu_1;
  localparam int INPUT = 8;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        oflow;
    logic        err;
    logic        g;
    logic        l;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t held  = '0;

  alu_1_if #(.INPUT(INPUT)) bus ();
  alu_1 #(.INPUT(INPUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [15:0] res, logic cout, logic oflow, logic err,
                              logic g, logic l, logic e);
    exp_t x;
    x.res = res; x.cout = cout; x.oflow = oflow; x.err = err; x.g = g; x.l = l; x.e = e;
    return x;
  endfunction

  // Behavioural model: plain integer arithmetic on the command definitions.
  function automatic exp_t model(bit mode, int cmd, bit [1:0] valid, int a, int b, bit cin);
    exp_t x = '0;
    int r = 0, need = 3, sa, sb, amt;
    bit undef = 0;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    amt = b % 8;
    if (mode) begin
      case (cmd)
        0:  begin r = a + b;       x.res = 16'(r); x.cout = (r > 255); end
        1:  begin r = a - b;       x.res = 16'(r & 'h1FF); x.oflow = (r < 0); end
        2:  begin r = a + b + cin; x.res = 16'(r); x.cout = (r > 255); end
        3:  begin r = a - b - cin; x.res = 16'(r & 'h1FF); x.oflow = (r < 0); end
        4:  begin need = 1; r = a + 1; x.res = 16'(r); x.cout = (r > 255); end
        5:  begin need = 1; r = a - 1; x.res = 16'(r & 'h1FF); x.oflow = (r < 0); end
        6:  begin need = 2; r = b + 1; x.res = 16'(r); x.cout = (r > 255); end
        7:  begin need = 2; r = b - 1; x.res = 16'(r & 'h1FF); x.oflow = (r < 0); end
        8:  begin x.g = (a > b); x.l = (a < b); x.e = (a == b); end
        9:  x.res = 16'(((a + 1) * (b + 1)) & 'hFFFF);
        10: x.res = 16'((2 * a * b) & 'hFFFF);
        11, 12: begin
          r = (cmd == 11) ? sa + sb : sa - sb;
          x.res   = 16'(r);
          x.oflow = (r > 127) || (r < -128);
          x.g = (sa > sb); x.l = (sa < sb); x.e = (sa == sb);
        end
        default: undef = 1;
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = ~(a & b) & 255;
        2:  r = a | b;
        3:  r = ~(a | b) & 255;
        4:  r = a ^ b;
        5:  r = ~(a ^ b) & 255;
        6:  begin need = 1; r = 255 - a; end
        7:  begin need = 2; r = 255 - b; end
        8:  begin need = 1; r = a / 2; end
        9:  begin need = 1; r = (a * 2) & 255; end
        10: begin need = 2; r = b / 2; end
        11: begin need = 2; r = (b * 2) & 255; end
        12: begin r = ((a << amt) | (a >> (8 - amt))) & 255; x.err = (b >= 8); end
        13: begin r = ((a >> amt) | (a << (8 - amt))) & 255; x.err = (b >= 8); end
        default: undef = 1;
      endcase
      x.res = 16'(r);
    end
    if (undef || ((int'(valid) & need) != need)) begin
      x     = '0;
      x.err = 1'b1;
    end
    return x;
  endfunction

  task automatic check(string tag, exp_t exp);
    exp_t obs;
    obs = {bus.res, bus.cout, bus.oflow, bus.err, bus.g, bus.l, bus.e};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed res=%h cout=%b oflow=%b err=%b g=%b l=%b e=%b expected res=%h cout=%b oflow=%b err=%b g=%b l=%b e=%b",
             tag, obs.res, obs.cout, obs.oflow, obs.err, obs.g, obs.l, obs.e,
             exp.res, exp.cout, exp.oflow, exp.err, exp.g, exp.l, exp.e);
    end
  endtask

  task automatic drive(bit ce, bit mode, logic [3:0] cmd, logic [1:0] valid,
                       logic [7:0] a, logic [7:0] b, bit cin);
    @(negedge clk);
    bus.ce = ce; bus.mode = mode; bus.cmd = cmd; bus.valid = valid;
    bus.opa = a; bus.opb = b; bus.cin = cin;
  endtask

  task automatic step(string tag, bit ce, bit mode, logic [3:0] cmd, logic [1:0] valid,
                      logic [7:0] a, logic [7:0] b, bit cin, exp_t exp);
    drive(ce, mode, cmd, valid, a, b, cin);
    @(posedge clk);
    #1;
    check(tag, exp);
    held = exp;
  endtask

  initial begin
    bit         ce, mode, cin;
    logic [3:0] cmd;
    logic [1:0] valid;
    logic [7:0] a, b;
    exp_t       exp;

    rst = 1'b1;
    bus.ce = 1'b0; bus.mode = 1'b0; bus.cmd = '0; bus.valid = '0;
    bus.opa = '0; bus.opb = '0; bus.cin = 1'b0;
    #12;
    check("reset_idle", '0);

    // CE=1 with a valid ADD must not escape while reset is held.
    drive(1, 1, 4'd0, 2'b11, 8'd50, 8'd25, 0);
    @(posedge clk); #1;
    check("reset_over_ce", '0);

    // Released with CE=0: nothing is evaluated yet.
    drive(0, 1, 4'd0, 2'b11, 8'd50, 8'd25, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_ce0", '0);

    step("missing_ops",  1, 1, 4'd0,  2'b00, 8'd1,   8'd1,   0, mk(16'd0,    0, 0, 1, 0, 0, 0));
    step("add_50_25",    1, 1, 4'd0,  2'b11, 8'd50,  8'd25,  0, mk(16'd75,   0, 0, 0, 0, 0, 0));
    step("arith_undef",  1, 1, 4'd15, 2'b11, 8'd50,  8'd25,  0, mk(16'd0,    0, 0, 1, 0, 0, 0));
    step("cmp_gt",       1, 1, 4'd8,  2'b11, 8'd50,  8'd25,  0, mk(16'd0,    0, 0, 0, 1, 0, 0));
    step("rol_hi_b",     1, 0, 4'd12, 2'b11, 8'hF0,  8'hC8,  0, mk(16'h00F0, 0, 0, 1, 0, 0, 0));
    step("ror_hi_b",     1, 0, 4'd13, 2'b11, 8'hF0,  8'h63,  0, mk(16'h001E, 0, 0, 1, 0, 0, 0));
    step("notb_no_b",    1, 0, 4'd7,  2'b01, 8'h0F,  8'h00,  0, mk(16'd0,    0, 0, 1, 0, 0, 0));
    step("shra_no_a",    1, 0, 4'd8,  2'b10, 8'h0F,  8'h00,  0, mk(16'd0,    0, 0, 1, 0, 0, 0));
    step("nota_a_only",  1, 0, 4'd6,  2'b01, 8'h0F,  8'h33,  0, mk(16'h00F0, 0, 0, 0, 0, 0, 0));
    step("add_carry",    1, 1, 4'd0,  2'b11, 8'hFF,  8'h01,  0, mk(16'h0100, 1, 0, 0, 0, 0, 0));
    step("sub_borrow",   1, 1, 4'd1,  2'b11, 8'd5,   8'd6,   0, mk(16'h01FF, 0, 1, 0, 0, 0, 0));
    step("mul_inc",      1, 1, 4'd9,  2'b11, 8'd3,   8'd4,   0, mk(16'd20,   0, 0, 0, 0, 0, 0));
    step("mul_inc_wrap", 1, 1, 4'd9,  2'b11, 8'hFF,  8'hFF,  0, mk(16'h0000, 0, 0, 0, 0, 0, 0));
    step("mul_shl_trun", 1, 1, 4'd10, 2'b11, 8'hFF,  8'hFF,  0, mk(16'hFC02, 0, 0, 0, 0, 0, 0));
    step("addcin_max",   1, 1, 4'd2,  2'b11, 8'hFF,  8'hFF,  1, mk(16'h01FF, 1, 0, 0, 0, 0, 0));
    step("subcin_brw",   1, 1, 4'd3,  2'b11, 8'd5,   8'd5,   1, mk(16'h01FF, 0, 1, 0, 0, 0, 0));
    step("deca_zero",    1, 1, 4'd5,  2'b01, 8'd0,   8'd9,   0, mk(16'h01FF, 0, 1, 0, 0, 0, 0));
    step("incb_max",     1, 1, 4'd6,  2'b10, 8'd7,   8'hFF,  0, mk(16'h0100, 1, 0, 0, 0, 0, 0));
    step("sadd_ovf",     1, 1, 4'd11, 2'b11, 8'h7F,  8'h01,  0, mk(16'h0080, 0, 1, 0, 1, 0, 0));
    step("ssub_ovf",     1, 1, 4'd12, 2'b11, 8'h80,  8'h01,  0, mk(16'hFF7F, 0, 1, 0, 0, 1, 0));
    step("rol_by1",      1, 0, 4'd12, 2'b11, 8'h81,  8'h01,  0, mk(16'h0003, 0, 0, 0, 0, 0, 0));

    // CE=0 holds the previous result while inputs change.
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 0, 1, 4'(i), 2'b11, 8'(i * 37), 8'hFF, 1,
           mk(16'h0003, 0, 0, 0, 0, 0, 0));

    step("pre_reset",    1, 1, 4'd0,  2'b11, 8'hFF,  8'h01,  0, mk(16'h0100, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", '0);
    @(posedge clk); #1;
    check("rst_held", '0);
    @(negedge clk);
    rst  = 1'b0;
    held = '0;
    step("after_reset",  1, 1, 4'd8,  2'b11, 8'd3,   8'd3,   0, mk(16'd0,    0, 0, 0, 0, 0, 1));

    // Randomized commands against the integer model; CE=0 expects the held value.
    for (int i = 0; i < 400; i++) begin
      ce    = ($urandom_range(0, 4) != 0);
      mode  = 1'($urandom_range(0, 1));
      cmd   = 4'($urandom_range(0, 15));
      valid = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      case ($urandom_range(0, 5))
        0:       begin a = 8'h00; b = 8'($urandom); end
        1:       begin a = 8'hFF; b = 8'($urandom); end
        2:       begin a = 8'($urandom); b = 8'($urandom_range(0, 7)); end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      cin = 1'($urandom_range(0, 1));
      exp = ce ? model(mode, int'(cmd), valid, int'(a), int'(b), cin) : held;
      step($sformatf("rnd%0d_m%0d_c%0d", i, mode, cmd), ce, mode, cmd, valid, a, b, cin, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
